// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch, PC register and IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        pc_sel,
  input  logic [31:0] pc_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_F,
  output logic [31:0] Instr_D,
  output logic [31:0] PC_D,
  output logic [31:0] PCplus4_D,
  output logic        valid_D,
  output logic [31:0] fetch_count
);
  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] instr_d_q, instr_d_d;
  logic [31:0] pc_d_q, pc_d_d;
  logic [31:0] pcplus4_d_q, pcplus4_d_d;
  logic        valid_d_q, valid_d_d;
  logic [31:0] count_q, count_d;
  logic [31:0] pc_f_plus4;
  logic        accept;
  assign pc_f_plus4 = pc_f_q + 32'd4;
  assign accept     = stallD && !flushD;
  // A redirect overrides stallF because the hazard unit drops stallF while redirecting.
  always_comb begin
    pc_f_d      = pc_sel ? {pc_target[31:2], 2'b00} : stallF ? pc_f_plus4 : pc_f_q;
    instr_d_d   = flushD ? NOP_INSTR : stallD ? imem_rdata : instr_d_q;
    pc_d_d      = flushD ? 32'd0 : stallD ? pc_f_q : pc_d_q;
    pcplus4_d_d = flushD ? 32'd0 : stallD ? pc_f_plus4 : pcplus4_d_q;
    valid_d_d   = flushD ? 1'b0 : stallD ? 1'b1 : valid_d_q;
    count_d     = accept ? count_q + 32'd1 : count_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_f_q      <= RESET_PC;
      instr_d_q   <= NOP_INSTR;
      pc_d_q      <= 32'd0;
      pcplus4_d_q <= 32'd0;
      valid_d_q   <= 1'b0;
      count_q     <= 32'd0;
    end else begin
      pc_f_q      <= pc_f_d;
      instr_d_q   <= instr_d_d;
      pc_d_q      <= pc_d_d;
      pcplus4_d_q <= pcplus4_d_d;
      valid_d_q   <= valid_d_d;
      count_q     <= count_d;
    end
  end
  assign PC_F        = pc_f_q;
  assign imem_addr   = pc_f_q;
  assign Instr_D     = instr_d_q;
  assign PC_D        = pc_d_q;
  assign PCplus4_D   = pcplus4_d_q;
  assign valid_D     = valid_d_q;
  assign fetch_count = count_q;
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the classical 5-stage pipelined RV32I core: holds the program counter, drives the instruction-memory address, and owns the IF/ID pipeline register. It sits directly upstream of decode. It consumes the stall, flush and redirect controls produced by the hazard unit and the execute-stage branch/jump logic, and feeds decode with the fetched instruction, its PC, and PC+4.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) inserted on flush/reset.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- stallF  in  1  fetch enable from hazard unit; 1 = PC may advance, 0 = hold PC (load-use stall).
- stallD  in  1  decode enable from hazard unit; 1 = IF/ID captures, 0 = IF/ID holds.
- flushD  in  1  1 = IF/ID loads a bubble on the next edge.
- pc_sel  in  1  1 = taken branch/jump resolved in execute; redirect PC.
- pc_target  in  32  redirect target from execute.
- imem_addr  out  32  instruction-memory address, equal to PC_F (combinational).
- imem_rdata  in  32  instruction word, combinational read of imem_addr.
- PC_F  out  32  current fetch PC.
- Instr_D  out  32  IF/ID instruction.
- PC_D  out  32  IF/ID PC.
- PCplus4_D  out  32  IF/ID PC+4.
- valid_D  out  1  1 = Instr_D is a real fetched instruction; 0 = bubble.
- fetch_count  out  32  number of instructions accepted into IF/ID since reset.

## Operation
- The PC register updates on every edge with this priority:
  - pc_sel=1: PC_F <= {pc_target[31:2],2'b00}. This applies regardless of stallF. The hazard unit deasserts stallF during a redirect, so pc_sel must override it.
  - else stallF=1: PC_F <= PC_F+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
  - else: hold.
- PC_F[1:0] is always 0. pc_target[1:0] is ignored, and no misalignment trap is raised.
- The IF/ID register updates on every edge with this priority:
  - flushD=1: Instr_D<=NOP_INSTR, PC_D<=0, PCplus4_D<=0, valid_D<=0. Flush wins over stallD=0.
  - else stallD=1: Instr_D<=imem_rdata, PC_D<=PC_F, PCplus4_D<=PC_F+4, valid_D<=1.
  - else: hold all four fields unchanged.
- fetch_count increments by 1 on each edge where stallD=1 and flushD=0. It wraps modulo 2^32 and never saturates.
- No FSM beyond the PC and IF/ID registers. The block does not resolve branches and does not decode instructions.

## Timing
- Reset (rst=0, asynchronous, immediate):
  - PC_F=RESET_PC, so imem_addr=RESET_PC.
  - Instr_D=NOP_INSTR, PC_D=0, PCplus4_D=0, valid_D=0.
  - fetch_count=0.
- Release is synchronous to the first rising edge with rst=1.
- Reset asserted mid-operation, including during a stall or redirect, discards all state immediately.
- Fetch latency is 1 cycle: the word at PC_F in cycle n appears on Instr_D in cycle n+1 (stallD=1, flushD=0).
- Redirect with pc_sel=1 in cycle n (hazard unit gives flushD=1, stallF=stallD=0):
  - Cycle n+1: PC_F=target, valid_D=0.
  - Cycle n+2: the target instruction is in Instr_D.
- Load-use stall (stallF=stallD=0, flushD=0): PC_F and all IF/ID fields are unchanged for each stalled cycle. fetch_count is unchanged.
- Simultaneous pc_sel=1 and stallF=0: the redirect is taken.
- Simultaneous flushD=1 and stallD=0: the bubble is inserted.

## Test plan
- Reset: assert rst=0 mid-cycle with RESET_PC=0x100 → PC_F=0x100, Instr_D=0x00000013, valid_D=0, fetch_count=0 immediately, without waiting for a clock edge.
- Sequential fetch: imem returns the word {PC} for 4 cycles, with stallF=stallD=1 → PC_F = 0x104, 0x108, 0x10C, 0x110. Instr_D lags PC_F by one cycle, PCplus4_D=PC_D+4, and fetch_count=4.
- Load-use stall: hold stallF=stallD=0 for 2 cycles at PC_F=0x108 → PC_F, Instr_D and PC_D are frozen and fetch_count does not change. Advancing resumes from 0x10C.
- Redirect: pc_sel=1, pc_target=0x203, flushD=1, stallF=stallD=0 at PC_F=0x110 → next cycle PC_F=0x200, valid_D=0, Instr_D=NOP. The cycle after, PC_D=0x200 and valid_D=1.
- Wrap: force PC_F=0xFFFF_FFFC via a redirect, then advance → PC_F=0x0000_0000 and PCplus4_D=0x0000_0000 for that entry.
- Counter wrap and priority: preload fetch_count near 0xFFFF_FFFF by fetching, then accept one more → 0. Drive flushD=1 with stallD=1 → bubble inserted and the count does not increment.
